// File: rtl/bcd_seg_driver_if.sv
// Bus bundle for bcd_seg_driver.
// Ports:
//   din        value to display (write data)
//   din_valid  one-cycle write strobe
//   busy       conversion/update in progress
//   done       one-cycle pulse after the segment outputs change
//   dout0..2   ones/tens/hundreds segment patterns (active-low, bit0=a..bit6=g)
interface bcd_seg_driver_if;
  logic [7:0] din;
  logic       din_valid;
  logic       busy;
  logic       done;
  logic [6:0] dout0;
  logic [6:0] dout1;
  logic [6:0] dout2;

  modport master (
    output din, din_valid,
    input  busy, done, dout0, dout1, dout2
  );

  modport slave (
    input  din, din_valid,
    output busy, done, dout0, dout1, dout2
  );
endinterface

// File: rtl/bcd_seg_driver.sv
// Binary-to-seven-segment driver: each strobed byte is converted to three
// BCD digits by a serial shift-add-3 engine (one bit per clock), then the
// three segment patterns are registered in a single update cycle.
// Strobes arriving mid-conversion are held in a one-entry, latest-wins slot.
// Ports:
//   clk   system clock (rising edge)
//   rstn  asynchronous active-low reset
//   bus   slave side of bcd_seg_driver_if (din/din_valid in, busy/done/dout* out)
//
// state  | meaning
// IDLE   | waiting for a strobe, outputs hold last value
// CONV   | shifting one input bit per clock into the BCD register (8 edges)
// UPDATE | encode BCD, register segments, pulse done, chain or return
module bcd_seg_driver #(
  parameter int DATA_WIDTH    = 8,
  parameter bit BLANK_LEADING = 1'b0
) (
  input logic             clk,
  input logic             rstn,
  bcd_seg_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_RST2  = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
  localparam logic [3:0] CNT_LAST  = 4'(DATA_WIDTH - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] pend_q;
  logic                  pend_vld_q;
  logic [11:0]           bcd_q;
  logic [3:0]            cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [6:0]            seg0_q, seg1_q, seg2_q;

  logic [11:0]           bcd_adj;
  logic                  hund_zero, tens_zero;
  logic [6:0]            seg0_d, seg1_d, seg2_d;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // All three nibbles are corrected from pre-edge values before the shift.
  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  // Only used on the UPDATE edge, when bcd_q holds the finished digits.
  always_comb begin
    hund_zero = (bcd_q[11:8] == 4'd0);
    tens_zero = hund_zero && (bcd_q[7:4] == 4'd0);
    seg0_d    = seg_enc(bcd_q[3:0]);
    seg1_d    = (BLANK_LEADING && tens_zero) ? SEG_BLANK : seg_enc(bcd_q[7:4]);
    seg2_d    = (BLANK_LEADING && hund_zero) ? SEG_BLANK : seg_enc(bcd_q[11:8]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg0_q     <= SEG_ZERO;
      seg1_q     <= SEG_RST2;
      seg2_q     <= SEG_RST2;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.din_valid) begin
            shift_q <= bus.din;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          cnt_q            <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state_q <= UPDATE;
          if (bus.din_valid) begin
            pend_q     <= bus.din;
            pend_vld_q <= 1'b1;
          end
        end
        UPDATE: begin
          seg0_q <= seg0_d;
          seg1_q <= seg1_d;
          seg2_q <= seg2_d;
          done_q <= 1'b1;
          // A strobe on this edge is newer than anything pending.
          if (bus.din_valid || pend_vld_q) begin
            shift_q    <= bus.din_valid ? bus.din : pend_q;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            state_q    <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout0 = seg0_q;
  assign bus.dout1 = seg1_q;
  assign bus.dout2 = seg2_q;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Self-checking bench for bcd_seg_driver. Two instances (no blanking /
// leading-zero blanking) receive identical stimulus; expected displays are
// queued when a value is strobed and compared whenever done pulses.
module tb_bcd_seg_driver;

  logic clk;
  logic rstn;

  bcd_seg_driver_if bus0 ();
  bcd_seg_driver_if bus1 ();

  bcd_seg_driver #(.DATA_WIDTH(8), .BLANK_LEADING(1'b0)) u_dut0 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus0)
  );

  bcd_seg_driver #(.DATA_WIDTH(8), .BLANK_LEADING(1'b1)) u_dut1 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic [20:0] exp0;  // {dout2,dout1,dout0}, no blanking
    logic [20:0] exp1;  // {dout2,dout1,dout0}, leading-zero blanking
  } vec_t;

  typedef struct {
    logic [7:0]  din;
    logic [20:0] e0;
    logic [20:0] e1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc_ref(input int d);
    case (d)
      0: enc_ref = 7'h40;
      1: enc_ref = 7'h79;
      2: enc_ref = 7'h24;
      3: enc_ref = 7'h30;
      4: enc_ref = 7'h19;
      5: enc_ref = 7'h12;
      6: enc_ref = 7'h02;
      7: enc_ref = 7'h78;
      8: enc_ref = 7'h00;
      9: enc_ref = 7'h10;
      default: enc_ref = 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] model(input int v, input bit blank);
    int h, t, o;
    logic [6:0] s2, s1;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    s2 = (blank && h == 0) ? 7'h7F : enc_ref(h);
    s1 = (blank && h == 0 && t == 0) ? 7'h7F : enc_ref(t);
    model = {s2, s1, enc_ref(o)};
  endfunction

  task automatic push_exp(input logic [7:0] v, input logic [20:0] e0, input logic [20:0] e1);
    exp_t e;
    e.din = v;
    e.e0  = e0;
    e.e1  = e1;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; the strobe is sampled at the next edge.
  task automatic strobe(input logic [7:0] v);
    bus0.din       = v;
    bus1.din       = v;
    bus0.din_valid = 1'b1;
    bus1.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus0.din_valid = 1'b0;
    bus1.din_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus0.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus0.busy) check("idle timeout", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Scoreboard: every done pulse must match the oldest expected display.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.busy) busy_cnt++;
    if (bus0.done) done_cnt++;
    check("busy agree", 32'(bus1.busy), 32'(bus0.busy));
    if (bus0.done) begin
      if (sb.size() == 0) begin
        check("spurious done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("dout dut0 din=%0d", e.din),
              32'({bus0.dout2, bus0.dout1, bus0.dout0}), 32'(e.e0));
        check($sformatf("dout dut1 din=%0d", e.din),
              32'({bus1.dout2, bus1.dout1, bus1.dout0}), 32'(e.e1));
        check("done dut1", 32'(bus1.done), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] rv;

    tbl[0] = '{8'd0,   {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    tbl[1] = '{8'd7,   {7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h78}};
    tbl[2] = '{8'd105, {7'h79, 7'h40, 7'h12}, {7'h79, 7'h40, 7'h12}};
    tbl[3] = '{8'd9,   {7'h40, 7'h40, 7'h10}, {7'h7F, 7'h7F, 7'h10}};
    tbl[4] = '{8'd99,  {7'h40, 7'h10, 7'h10}, {7'h7F, 7'h10, 7'h10}};
    tbl[5] = '{8'd100, {7'h79, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40}};
    tbl[6] = '{8'd45,  {7'h40, 7'h19, 7'h12}, {7'h7F, 7'h19, 7'h12}};
    tbl[7] = '{8'd123, {7'h79, 7'h24, 7'h30}, {7'h79, 7'h24, 7'h30}};

    rstn           = 1'b0;
    bus0.din       = '0;
    bus1.din       = '0;
    bus0.din_valid = 1'b0;
    bus1.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("reset dout dut0", 32'({bus0.dout2, bus0.dout1, bus0.dout0}), 32'({7'h40, 7'h40, 7'h40}));
    check("reset dout dut1", 32'({bus1.dout2, bus1.dout1, bus1.dout0}), 32'({7'h7F, 7'h7F, 7'h40}));
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done | bus1.done), 32'd0);
    tick();

    // 255: busy for exactly 9 cycles, single done
    busy_cnt = 0;
    done_cnt = 0;
    push_exp(8'd255, {7'h24, 7'h12, 7'h12}, {7'h24, 7'h12, 7'h12});
    strobe(8'd255);
    wait_idle();
    check("busy cycles 255", 32'(busy_cnt), 32'd9);
    check("done pulses 255", 32'(done_cnt), 32'd1);

    foreach (tbl[i]) begin
      push_exp(tbl[i].din, tbl[i].exp0, tbl[i].exp1);
      strobe(tbl[i].din);
      wait_idle();
    end

    for (int i = 0; i < 6; i++) begin
      rv = 8'($urandom_range(0, 255));
      push_exp(rv, model(int'(rv), 1'b0), model(int'(rv), 1'b1));
      strobe(rv);
      wait_idle();
    end

    // 123 then 45, 200 during CONV: 45 is dropped
    busy_cnt = 0;
    done_cnt = 0;
    push_exp(8'd123, {7'h79, 7'h24, 7'h30}, {7'h79, 7'h24, 7'h30});
    strobe(8'd123);
    tick();
    strobe(8'd45);
    tick();
    push_exp(8'd200, {7'h24, 7'h40, 7'h40}, {7'h24, 7'h40, 7'h40});
    strobe(8'd200);
    wait_idle();
    check("busy cycles pending", 32'(busy_cnt), 32'd18);
    check("done pulses pending", 32'(done_cnt), 32'd2);

    // 99 strobed on the UPDATE edge of 10
    busy_cnt = 0;
    done_cnt = 0;
    push_exp(8'd10, {7'h40, 7'h79, 7'h40}, {7'h7F, 7'h79, 7'h40});
    strobe(8'd10);
    repeat (8) tick();
    push_exp(8'd99, {7'h40, 7'h10, 7'h10}, {7'h7F, 7'h10, 7'h10});
    strobe(8'd99);
    wait_idle();
    check("busy cycles chained", 32'(busy_cnt), 32'd18);
    check("done pulses chained", 32'(done_cnt), 32'd2);

    // Reset at counter=4 while converting 200 with 77 pending
    strobe(8'd200);
    tick();
    strobe(8'd77);
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    check("midreset dout dut0", 32'({bus0.dout2, bus0.dout1, bus0.dout0}), 32'({7'h40, 7'h40, 7'h40}));
    check("midreset dout dut1", 32'({bus1.dout2, bus1.dout1, bus1.dout0}), 32'({7'h7F, 7'h7F, 7'h40}));
    check("midreset busy", 32'(bus0.busy | bus1.busy), 32'd0);
    check("midreset done", 32'(bus0.done | bus1.done), 32'd0);
    tick();
    rstn = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (12) tick();
    check("no stale busy", 32'(busy_cnt), 32'd0);
    check("no stale done", 32'(done_cnt), 32'd0);
    push_exp(8'd1, {7'h40, 7'h40, 7'h79}, {7'h7F, 7'h7F, 7'h79});
    strobe(8'd1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
